// File: rtl/global_fsm_task_sequencer_pkg.sv
// Shared definitions for the global task sequencer: state codes, state enum and
// the field layout of the concatenated kernel scalars.
package global_fsm_task_sequencer_pkg;

  localparam logic [1:0] ST_IDLE_CODE   = 2'b00;
  localparam logic [1:0] ST_START_CODE  = 2'b01;
  localparam logic [1:0] ST_RUN_CODE    = 2'b11;
  localparam logic [1:0] ST_FINISH_CODE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_CODE,
    ST_START  = ST_START_CODE,
    ST_RUN    = ST_RUN_CODE,
    ST_FINISH = ST_FINISH_CODE
  } state_e;

  // Scalar layout: mmap offset in the low 64 bits, seq_len above it.
  localparam int OFFSET_LSB      = 0;
  localparam int OFFSET_W        = 64;
  localparam int SEQ_LEN_LSB     = 64;
  localparam int SEQ_LEN_W       = 32;
  localparam int SCALAR_FIELDS_W = SEQ_LEN_LSB + SEQ_LEN_W;

  function automatic logic [SCALAR_FIELDS_W-1:0] pack_scalars(
    input logic [OFFSET_W-1:0]  offset,
    input logic [SEQ_LEN_W-1:0] seq_len
  );
    logic [SCALAR_FIELDS_W-1:0] packed_scalars;
    packed_scalars = '0;
    packed_scalars[OFFSET_LSB +: OFFSET_W]   = offset;
    packed_scalars[SEQ_LEN_LSB +: SEQ_LEN_W] = seq_len;
    return packed_scalars;
  endfunction

endpackage

// File: rtl/global_fsm_task_sequencer_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/global_fsm_task_sequencer.sv
// Host-facing control FSM: accepts ap_start, broadcasts latched scalars and a
// global start to the task FSMs, waits for all of them, then pulses done.
module global_fsm_task_sequencer
  import global_fsm_task_sequencer_pkg::*;
#(
  parameter int N_TASKS  = 4,
  parameter int SCALAR_W = 96,
  parameter int CNT_W    = 32
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_ready,
  output logic                ap_done,
  output logic                ap_idle,
  input  logic [SCALAR_W-1:0] s_scalars,
  output logic [SCALAR_W-1:0] global_fsm_s_scalars,
  output logic                global_fsm_ap_start,
  output logic                global_fsm_ap_done,
  input  logic [N_TASKS-1:0]  task_is_done,
  output logic [CNT_W-1:0]    run_cycles,
  output logic [N_TASKS-1:0]  done_seen
);

  state_e              state_q;
  state_e              state_d;
  logic [SCALAR_W-1:0] scalars_q;
  logic [SCALAR_W-1:0] scalars_d;
  logic [N_TASKS-1:0]  done_seen_q;
  logic [N_TASKS-1:0]  done_seen_d;
  logic                all_done;
  logic                cnt_clear;
  logic                cnt_en;

  // Completion is judged on the live flags; done_seen is only a debug record.
  assign all_done = &task_is_done;

  always_comb begin
    state_d             = state_q;
    scalars_d           = scalars_q;
    done_seen_d         = done_seen_q;
    ap_idle             = 1'b0;
    ap_ready            = 1'b0;
    ap_done             = 1'b0;
    global_fsm_ap_start = 1'b0;
    global_fsm_ap_done  = 1'b0;
    cnt_clear           = 1'b0;
    cnt_en              = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_d   = ST_START;
          scalars_d = s_scalars;
        end
      end
      ST_START: begin
        ap_ready            = 1'b1;
        global_fsm_ap_start = 1'b1;
        cnt_clear           = 1'b1;
        done_seen_d         = '0;
        state_d             = ST_RUN;
      end
      ST_RUN: begin
        cnt_en      = 1'b1;
        done_seen_d = done_seen_q | task_is_done;
        if (all_done) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        ap_done            = 1'b1;
        global_fsm_ap_done = 1'b1;
        state_d            = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= ST_IDLE;
      scalars_q   <= '0;
      done_seen_q <= '0;
    end else begin
      state_q     <= state_d;
      scalars_q   <= scalars_d;
      done_seen_q <= done_seen_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_run_counter (
    .clk  (ap_clk),
    .rst  (ap_rst),
    .clear(cnt_clear),
    .en   (cnt_en),
    .count(run_cycles)
  );

  assign global_fsm_s_scalars = scalars_q;
  assign done_seen            = done_seen_q;

endmodule

// File: tb/tb_global_fsm_task_sequencer.sv
// Self-checking bench for global_fsm_task_sequencer: a timeline-level reference
// model is compared against two DUT instances (32-bit and 4-bit run counters).
module tb_global_fsm_task_sequencer;
   import global_fsm_task_sequencer_pkg::*;

   localparam int NT = 4;
   localparam int SW = 96;
   localparam int CYCLE_BUDGET = 100;
   localparam longint MAX_MAIN = 64'hFFFF_FFFF;
   localparam longint MAX_SAT = 15;

   logic ap_clk = 1'b0;
   logic ap_rst = 1'b0;
   logic ap_start = 1'b0;
   logic [SW-1:0] s_scalars = '0;
   logic [NT-1:0] task_is_done = '0;

   logic ap_ready, ap_done, ap_idle, gStart, gDone;
   logic [SW-1:0] gScalars;
   logic [31:0] runCycles;
   logic [NT-1:0] doneSeen;

   logic satReady, satDone, satIdle, satGStart, satGDone;
   logic [SW-1:0] satScalars;
   logic [3:0] satRunCycles;
   logic [NT-1:0] satDoneSeen;

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   // Reference model state, expressed as a timeline: the cycle number in which
   // the current run's START and FINISH happen, plus run-cycle and done history.
   int cyc = 0;
   bit busy = 1'b0;
   int startAt = -10;
   int finAt = -1;
   longint cnt = 0;
   logic [NT-1:0] seen = '0;
   logic [SW-1:0] mScal = '0;

   global_fsm_task_sequencer #(.N_TASKS(NT), .SCALAR_W(SW), .CNT_W(32)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
      .s_scalars(s_scalars), .global_fsm_s_scalars(gScalars),
      .global_fsm_ap_start(gStart), .global_fsm_ap_done(gDone),
      .task_is_done(task_is_done), .run_cycles(runCycles), .done_seen(doneSeen)
   );

   global_fsm_task_sequencer #(.N_TASKS(NT), .SCALAR_W(SW), .CNT_W(4)) dutSat (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_ready(satReady), .ap_done(satDone), .ap_idle(satIdle),
      .s_scalars(s_scalars), .global_fsm_s_scalars(satScalars),
      .global_fsm_ap_start(satGStart), .global_fsm_ap_done(satGDone),
      .task_is_done(task_is_done), .run_cycles(satRunCycles), .done_seen(satDoneSeen)
   );

   // Free-running 10ns clock.
   always #5 ap_clk = ~ap_clk;

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   // One model step per clock edge: classify the cycle that just ended from the
   // run timeline, then accumulate counts/flags and decide start or finish.
   task automatic modelStep();
      int prev;
      bit prevStart;
      bit prevRun;
      if (ap_rst) begin
         busy = 1'b0;
         startAt = -10;
         finAt = -1;
         cnt = 0;
         seen = '0;
         mScal = '0;
      end else begin
         prev = cyc;
         cyc++;
         prevStart = busy && (prev == startAt);
         prevRun = busy && (prev > startAt) && (finAt < 0);
         if (prevStart) begin
            cnt = 0;
            seen = '0;
         end
         if (prevRun) begin
            cnt++;
            seen = seen | task_is_done;
         end
         if (busy && (finAt >= 0) && (prev == finAt)) begin
            busy = 1'b0;
         end else if (prevRun && (&task_is_done)) begin
            finAt = cyc;
         end else if (!busy && ap_start) begin
            busy = 1'b1;
            startAt = cyc;
            finAt = -1;
            mScal = s_scalars;
         end
      end
   endtask

   function automatic longint satTo(input longint value, input longint maxValue);
      return (value > maxValue) ? maxValue : value;
   endfunction

   // Drive the model on every clock edge and on asynchronous reset assertion.
   initial begin
      forever begin
         @(posedge ap_clk or posedge ap_rst);
         modelStep();
      end
   end

   // Compare both DUTs with the model in the middle of every cycle, where
   // all outputs are settled and no input is changing.
   initial begin
      forever begin
         @(negedge ap_clk);
         if (checking) begin
            checkOutput("ap_idle", 128'(ap_idle), 128'(!busy));
            checkOutput("ap_ready", 128'(ap_ready), 128'(busy && cyc == startAt));
            checkOutput("global_fsm_ap_start", 128'(gStart), 128'(busy && cyc == startAt));
            checkOutput("ap_done", 128'(ap_done), 128'(busy && cyc == finAt));
            checkOutput("global_fsm_ap_done", 128'(gDone), 128'(busy && cyc == finAt));
            checkOutput("global_fsm_s_scalars", 128'(gScalars), 128'(mScal));
            checkOutput("run_cycles", 128'(runCycles), 128'(satTo(cnt, MAX_MAIN)));
            checkOutput("done_seen", 128'(doneSeen), 128'(seen));
            checkOutput("sat_ap_idle", 128'(satIdle), 128'(!busy));
            checkOutput("sat_ap_ready", 128'(satReady), 128'(busy && cyc == startAt));
            checkOutput("sat_global_start", 128'(satGStart), 128'(busy && cyc == startAt));
            checkOutput("sat_ap_done", 128'(satDone), 128'(busy && cyc == finAt));
            checkOutput("sat_global_done", 128'(satGDone), 128'(busy && cyc == finAt));
            checkOutput("sat_scalars", 128'(satScalars), 128'(mScal));
            checkOutput("sat_run_cycles", 128'(satRunCycles), 128'(satTo(cnt, MAX_SAT)));
            checkOutput("sat_done_seen", 128'(satDoneSeen), 128'(seen));
         end
      end
   end

   // One host transaction: start in cycle 0, task i raises done from cycle tt[i]
   // and holds it; returns in the FINISH cycle, or after asserting reset at abortAt.
   task automatic applyStimulus(input logic [SW-1:0] sc, input int tt[4], input int abortAt,
                                output int readyAt, output int doneAt);
      bit ended;
      readyAt = -1;
      doneAt = -1;
      ended = 1'b0;
      for (int k = 0; k < CYCLE_BUDGET && !ended; k++) begin
         @(negedge ap_clk);
         #1;
         if (k == 0) begin
            ap_start = 1'b1;
            s_scalars = sc;
         end else begin
            if (ap_ready && readyAt < 0) readyAt = k;
            if (readyAt >= 0) begin
               ap_start = ($urandom_range(0, 3) == 0);
               s_scalars = {$urandom, $urandom, $urandom};
            end
         end
         if (k == abortAt) begin
            ap_rst = 1'b1;
            ap_start = 1'b0;
            task_is_done = '0;
            ended = 1'b1;
         end else begin
            for (int i = 0; i < NT; i++) task_is_done[i] = (k >= tt[i]);
            if (gDone) begin
               doneAt = k;
               ended = 1'b1;
            end
         end
      end
      if (!ended) begin
         checks++;
         errors++;
         $display("[TB] FAIL run_timeout: no global done within %0d cycles, expected one", CYCLE_BUDGET);
         ap_start = 1'b0;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge ap_clk);
         #1;
         ap_start = 1'b0;
         s_scalars = {$urandom, $urandom, $urandom};
         task_is_done = NT'($urandom);
      end
   endtask

   task automatic releaseReset();
      @(negedge ap_clk);
      #1;
      ap_rst = 1'b0;
      task_is_done = '0;
   endtask

   // Main sequence: reset, directed scenarios with literal expectations, then
   // randomized runs with occasional mid-run resets.
   initial begin
      int readyAt, doneAt;
      int tt[4];
      logic [SW-1:0] sc;

      #1 ap_rst = 1'b1;
      #1 checking = 1'b1;
      @(negedge ap_clk);
      #1;
      checkOutput("reset_ap_idle", 128'(ap_idle), 128'(1));
      checkOutput("reset_ap_ready", 128'(ap_ready), 128'(0));
      checkOutput("reset_ap_done", 128'(ap_done), 128'(0));
      checkOutput("reset_run_cycles", 128'(runCycles), 128'(0));
      checkOutput("reset_scalars", 128'(gScalars), 128'(0));
      releaseReset();
      idleCycles(2);

      sc = pack_scalars(64'h1000, 32'd128);
      applyStimulus(sc, '{5, 7, 7, 9}, -1, readyAt, doneAt);
      checkOutput("basic_ready_cycle", 128'(readyAt), 128'(1));
      checkOutput("basic_done_cycle", 128'(doneAt), 128'(10));
      checkOutput("basic_run_cycles", 128'(runCycles), 128'(8));
      checkOutput("basic_model_run_cycles", 128'(cnt), 128'(8));
      checkOutput("basic_done_seen", 128'(doneSeen), 128'(4'hF));
      checkOutput("basic_scalars", 128'(gScalars), 128'(sc));

      sc = pack_scalars(64'hDEAD_BEEF_0000_2000, 32'd77);
      applyStimulus(sc, '{3, 2, 4, 3}, -1, readyAt, doneAt);
      checkOutput("b2b_ready_cycle", 128'(readyAt), 128'(1));
      checkOutput("b2b_done_cycle", 128'(doneAt), 128'(5));
      checkOutput("b2b_scalars", 128'(gScalars), 128'(sc));

      @(negedge ap_clk);
      #1;
      ap_start = 1'b0;
      task_is_done = 4'hF;
      applyStimulus(pack_scalars(64'h42, 32'd1), '{0, 0, 0, 0}, -1, readyAt, doneAt);
      checkOutput("stale_ready_cycle", 128'(readyAt), 128'(1));
      checkOutput("stale_done_cycle", 128'(doneAt), 128'(3));
      checkOutput("stale_run_cycles", 128'(runCycles), 128'(1));
      idleCycles(1);

      applyStimulus(pack_scalars(64'h5000, 32'd9), '{3, 4, 50, 50}, 6, readyAt, doneAt);
      #1;
      checkOutput("midrst_ap_idle", 128'(ap_idle), 128'(1));
      checkOutput("midrst_done_seen", 128'(doneSeen), 128'(0));
      checkOutput("midrst_run_cycles", 128'(runCycles), 128'(0));
      checkOutput("midrst_ap_done", 128'(ap_done), 128'(0));
      releaseReset();
      idleCycles(3);

      applyStimulus(pack_scalars(64'h6000, 32'd20), '{21, 21, 21, 21}, -1, readyAt, doneAt);
      checkOutput("sat_done_cycle", 128'(doneAt), 128'(22));
      checkOutput("sat_main_run_cycles", 128'(runCycles), 128'(20));
      checkOutput("sat_small_run_cycles", 128'(satRunCycles), 128'(15));
      idleCycles(1);

      for (int r = 0; r < 40; r++) begin
         foreach (tt[i]) tt[i] = $urandom_range(0, 12);
         sc = {$urandom, $urandom, $urandom};
         if ($urandom_range(0, 9) == 0) begin
            applyStimulus(sc, tt, $urandom_range(1, 8), readyAt, doneAt);
            if (ap_rst) releaseReset();
         end else begin
            applyStimulus(sc, tt, -1, readyAt, doneAt);
         end
         idleCycles($urandom_range(0, 3));
      end

      idleCycles(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
